// File: rtl/rc4_stream_xor.sv
// Consumer side of an RC4 keystream: buffers keystream bytes, optionally discards the
// first DROP_N of each frame, then XORs one keystream byte onto each payload byte.
module rc4_stream_xor #(
    parameter int DEPTH  = 16,
    parameter int DROP_N = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ks_valid,
    output logic        ks_ready,
    input  logic [7:0]  ks_data,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [7:0]  din_data,
    input  logic        din_last,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [7:0]  dout_data,
    output logic        dout_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DROP, RUN, FLUSH} state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [9:0]  drop_cnt;

    logic       fifo_empty;
    logic       fifo_full;
    logic       ks_hs;
    logic       push;
    logic       din_hs;
    logic       dout_hs;
    logic [7:0] fifo_head;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = mem[rd_ptr[AW-1:0]];

    assign ks_ready  = (state == DROP) || ((state == RUN) && !fifo_full);
    assign din_ready = (state == RUN) && !fifo_empty && (!dout_valid || dout_ready);
    assign busy      = (state != IDLE);

    assign ks_hs   = ks_valid && ks_ready;
    assign push    = ks_hs && (state == RUN);
    assign din_hs  = din_valid && din_ready;
    assign dout_hs = dout_valid && dout_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ks_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            dout_valid <= 1'b0;
            dout_data  <= 8'h00;
            dout_last  <= 1'b0;
            done       <= 1'b0;
            byte_cnt   <= 16'h0000;
        end else begin
            done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (din_hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // A new byte replaces the held one; otherwise a handshake empties the slot.
            if (din_hs) begin
                dout_data  <= din_data ^ fifo_head;
                dout_last  <= din_last;
                dout_valid <= 1'b1;
                byte_cnt   <= byte_cnt + 16'd1;
            end else if (dout_hs) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt <= 16'h0000;
                        drop_cnt <= '0;
                        state    <= (DROP_N > 0) ? DROP : RUN;
                    end
                end
                DROP: begin
                    if (ks_hs) begin
                        drop_cnt <= drop_cnt + 10'd1;
                        if (11'(drop_cnt) + 11'd1 == 11'(DROP_N)) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (din_hs && din_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (dout_hs) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides everything above, including a completing flush.
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                dout_valid <= 1'b0;
                done       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// Directed bench for rc4_stream_xor: one instance without a drop phase, one with DROP_N=3.
module tb_rc4_stream_xor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        start = 0, abort = 0, ks_valid = 0, din_valid = 0, din_last = 0, dout_ready = 0;
    logic [7:0]  ks_data = 0, din_data = 0;
    logic        ks_ready, din_ready, dout_valid, dout_last, busy, done;
    logic [7:0]  dout_data;
    logic [15:0] byte_cnt;

    logic        b_start = 0, b_abort = 0, b_ks_valid = 0, b_din_valid = 0, b_din_last = 0;
    logic        b_dout_ready = 0;
    logic [7:0]  b_ks_data = 0, b_din_data = 0;
    logic        b_ks_ready, b_din_ready, b_dout_valid, b_dout_last, b_busy, b_done;
    logic [7:0]  b_dout_data;
    logic [15:0] b_byte_cnt;

    rc4_stream_xor #(.DEPTH(16), .DROP_N(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .busy(busy), .done(done), .byte_cnt(byte_cnt)
    );

    rc4_stream_xor #(.DEPTH(16), .DROP_N(3)) dut_drop (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .ks_valid(b_ks_valid), .ks_ready(b_ks_ready), .ks_data(b_ks_data),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
        .din_last(b_din_last), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
        .dout_data(b_dout_data), .dout_last(b_dout_last), .busy(b_busy), .done(b_done),
        .byte_cnt(b_byte_cnt)
    );

    typedef struct {
        logic [7:0] ks;
        logic [7:0] din;
        logic       last;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t basic [3];
    vec_t dropv [2];

    int tests = 0;
    int fails = 0;

    logic [7:0] ks_arr  [64];
    logic [7:0] din_arr [64];
    int   ks_idx, din_idx, out_idx, acc, sent;
    logic done_seen, stall, ksh, dh, oh;
    logic [7:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        basic[0] = '{8'h5A, 8'h12, 1'b0, 8'h48};
        basic[1] = '{8'hFF, 8'h34, 1'b0, 8'hCB};
        basic[2] = '{8'h00, 8'h56, 1'b1, 8'h56};
        dropv[0] = '{8'h04, 8'hAA, 1'b0, 8'hAE};
        dropv[1] = '{8'h05, 8'hAA, 1'b1, 8'hAF};
        for (int i = 0; i < 64; i++) begin
            ks_arr[i]  = 8'($urandom_range(0, 255));
            din_arr[i] = 8'($urandom_range(0, 255));
        end

        // Reset state
        step(); step();
        check("rst_ks_ready", ks_ready, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic XOR frame, table driven
        start = 1; step(); start = 0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 3; i++) begin
            ks_valid = 1; ks_data = basic[i].ks; #1;
            check("basic_ks_ready", ks_ready, 1);
            step();
        end
        ks_valid = 0;
        dout_ready = 1;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1; din_data = basic[i].din; din_last = basic[i].last; #1;
            check("basic_din_ready", din_ready, 1);
            step();
            $display("[TB] basic %0d: din=%02h ks=%02h -> dout=%02h last=%0b", i,
                     basic[i].din, basic[i].ks, dout_data, dout_last);
            check("basic_dout_valid", dout_valid, 1);
            check("basic_dout_data", dout_data, basic[i].exp_dout);
            check("basic_dout_last", dout_last, basic[i].last);
            check("basic_byte_cnt", byte_cnt, i + 1);
        end
        din_valid = 0; din_last = 0;
        check("basic_done_early", done, 0);
        step();
        check("basic_done", done, 1);
        check("basic_busy_after", busy, 0);
        check("basic_dout_valid_after", dout_valid, 0);
        step();
        check("basic_done_single", done, 0);

        // Drop phase on the DROP_N=3 instance
        b_start = 1; step(); b_start = 0;
        for (int i = 0; i < 5; i++) begin
            b_ks_valid = 1;
            b_ks_data = (i < 3) ? 8'(i + 1) : dropv[i - 3].ks;
            #1;
            check("drop_ks_ready", b_ks_ready, 1);
            if (i < 3) check("drop_din_ready", b_din_ready, 0);
            step();
        end
        b_ks_valid = 0;
        b_dout_ready = 1;
        for (int i = 0; i < 2; i++) begin
            b_din_valid = 1; b_din_data = dropv[i].din; b_din_last = dropv[i].last; #1;
            check("drop_din_ready_run", b_din_ready, 1);
            step();
            $display("[TB] drop %0d: din=%02h -> dout=%02h last=%0b", i,
                     dropv[i].din, b_dout_data, b_dout_last);
            check("drop_dout_data", b_dout_data, dropv[i].exp_dout);
            check("drop_dout_last", b_dout_last, dropv[i].last);
        end
        b_din_valid = 0; b_din_last = 0;
        step();
        check("drop_done", b_done, 1);
        check("drop_busy", b_busy, 0);
        check("drop_byte_cnt", b_byte_cnt, 2);
        check("drop_dout_valid", b_dout_valid, 0);

        // FIFO full
        start = 1; step(); start = 0;
        acc = 0; ks_valid = 1;
        for (int c = 0; c < 20; c++) begin
            ks_data = 8'h30 + 8'(acc); #1;
            if (ks_ready) acc++;
            step();
        end
        check("full_accepted", acc, 16);
        check("full_ks_ready", ks_ready, 0);
        din_valid = 1; din_data = 8'h0F; din_last = 0; dout_ready = 1; #1;
        check("full_push_blocked_on_pop", ks_ready, 0);
        check("full_din_ready", din_ready, 1);
        step(); din_valid = 0;
        check("full_ks_ready_back", ks_ready, 1);
        check("full_dout_data", dout_data, 8'h3F);
        ks_data = 8'h30 + 8'(acc); step();
        check("full_again", ks_ready, 0);
        ks_valid = 0;
        abort = 1; step(); abort = 0;
        check("full_abort_busy", busy, 0);
        check("full_abort_dout_valid", dout_valid, 0);

        // Backpressure with a 64-byte random stream
        start = 1; step(); start = 0;
        ks_idx = 0; din_idx = 0; out_idx = 0; done_seen = 0; held = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            stall = (c >= 20 && c < 25);
            ks_valid = (ks_idx < 64); ks_data = ks_arr[ks_idx % 64];
            din_valid = (din_idx < 64); din_data = din_arr[din_idx % 64];
            din_last = (din_idx == 63);
            dout_ready = !stall;
            #1;
            if (stall) begin
                check("stall_dout_valid", dout_valid, 1);
                check("stall_din_ready", din_ready, 0);
                if (c == 20) held = dout_data;
                else check("stall_hold", dout_data, held);
            end
            if (c >= 26 && c < 50) check("throughput", din_valid & din_ready, 1);
            if (done) begin
                done_seen = 1;
                check("stream_byte_cnt", byte_cnt, 64);
            end
            ksh = ks_valid & ks_ready;
            dh  = din_valid & din_ready;
            oh  = dout_valid & dout_ready;
            if (oh) begin
                check("stream_data", dout_data, ks_arr[out_idx % 64] ^ din_arr[out_idx % 64]);
                check("stream_last", dout_last, out_idx == 63);
                out_idx++;
            end
            step();
            if (ksh) ks_idx++;
            if (dh) din_idx++;
        end
        ks_valid = 0; din_valid = 0; din_last = 0; dout_ready = 1;
        check("stream_done_seen", done_seen, 1);
        check("stream_out_count", out_idx, 64);

        // Abort with 4 bytes left in the FIFO
        start = 1; step(); start = 0;
        ks_valid = 1;
        for (int i = 0; i < 5; i++) begin
            ks_data = 8'h10 + 8'(i); step();
        end
        ks_valid = 0;
        din_valid = 1; din_data = 8'h00; step(); din_valid = 0;
        check("abort_pre_dout", dout_data, 8'h10);
        dout_ready = 0;
        abort = 1; step(); abort = 0;
        check("abort_busy", busy, 0);
        check("abort_dout_valid", dout_valid, 0);
        check("abort_byte_cnt_hold", byte_cnt, 1);
        check("abort_no_done", done, 0);
        step();
        check("abort_no_done_later", done, 0);
        dout_ready = 1;
        start = 1; step(); start = 0;
        check("restart_byte_cnt", byte_cnt, 0);
        check("restart_fifo_empty", din_ready, 0);
        check("restart_ks_ready", ks_ready, 1);
        ks_valid = 1; ks_data = 8'h77; step(); ks_valid = 0;
        din_valid = 1; din_data = 8'h01; step(); din_valid = 0;
        check("restart_head_fresh", dout_data, 8'h76);
        start = 1; step(); start = 0;
        check("start_while_busy_ignored", byte_cnt, 1);
        abort = 1; step(); abort = 0;
        check("abort_to_idle", busy, 0);
        start = 1; abort = 1; step(); start = 0; abort = 0;
        check("start_beats_abort_in_idle", busy, 1);

        // Asynchronous reset mid-frame with a held output
        ks_valid = 1; ks_data = 8'h22; step(); ks_valid = 0;
        dout_ready = 0;
        din_valid = 1; din_data = 8'h33; step(); din_valid = 0;
        check("midrst_pre_valid", dout_valid, 1);
        #2 rst_n = 0; #1;
        check("midrst_dout_valid", dout_valid, 0);
        check("midrst_dout_data", dout_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_byte_cnt", byte_cnt, 0);
        check("midrst_ks_ready", ks_ready, 0);
        step();
        check("midrst_no_done", done, 0);
        rst_n = 1; dout_ready = 1;
        step();
        check("midrst_no_done_after", done, 0);

        // 65537-byte frame: byte_cnt wraps
        start = 1; step(); start = 0;
        sent = 0; done_seen = 0; ks_valid = 1; ks_data = 8'hC3; dout_ready = 1;
        for (int c = 0; c < 70000 && !done_seen; c++) begin
            din_valid = (sent < 65537); din_data = 8'h5A; din_last = (sent == 65536);
            #1;
            if (done) begin
                done_seen = 1;
                check("wrap_byte_cnt_done", byte_cnt, 1);
            end
            dh = din_valid & din_ready;
            step();
            if (dh) begin
                sent++;
                if (sent == 65536) begin
                    check("wrap_byte_cnt_zero", byte_cnt, 0);
                    check("wrap_dout_data", dout_data, 8'h99);
                end
            end
        end
        ks_valid = 0; din_valid = 0; din_last = 0;
        check("wrap_done_seen", done_seen, 1);
        check("wrap_sent", sent, 65537);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
